// File: rtl/bus_timer_pkg.sv
// bus_timer_pkg: register map, CTRL/STATUS bit positions and small helpers
// shared by the bus_timer peripheral and its prescaler.
package bus_timer_pkg;

    // Register addresses (rs)
    localparam logic [2:0] TMR_CNT_LO = 3'd0;
    localparam logic [2:0] TMR_CNT_HI = 3'd1;
    localparam logic [2:0] TMR_CTRL   = 3'd2;
    localparam logic [2:0] TMR_STATUS = 3'd3;
    localparam logic [2:0] TMR_CMP_LO = 3'd4;
    localparam logic [2:0] TMR_CMP_HI = 3'd5;

    // CTRL bit indices
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    // STATUS bit index
    localparam int STATUS_FLAG = 0;

    // CTRL readback: upper bits always read as zero
    function automatic logic [7:0] ctrl_byte(input logic [2:0] ctrl);
        return {5'b00000, ctrl};
    endfunction

    // STATUS readback: only the underflow flag is implemented
    function automatic logic [7:0] status_byte(input logic flag);
        logic [7:0] b;
        b = 8'h00;
        b[STATUS_FLAG] = flag;
        return b;
    endfunction

endpackage

// File: rtl/bus_timer_if.sv
// bus_timer_if: 65C02-side responder bus of the timer (select, write strobe,
// register select, data in/out) plus its irq and pwm outputs.
interface bus_timer_if;
    logic       cs;
    logic       we;
    logic [2:0] rs;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;
    logic       pwm;

    modport master (
        output cs, we, rs, din,
        input  dout, irq, pwm
    );

    modport slave (
        input  cs, we, rs, din,
        output dout, irq, pwm
    );
endinterface

// File: rtl/bus_timer_prescale.sv
// bus_timer_prescale: divides clk by PRESCALE to produce the timer tick.
// en low holds the counter at zero, so enabling always restarts a full
// PRESCALE-cycle period before the first tick.
module bus_timer_prescale #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int            PW   = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] cnt_r;

    // Prescale counter: held at zero while disabled, wraps after LAST
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (!en) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + ONE;
        end
    end

    assign tick = en & (cnt_r == LAST);

endmodule

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 16-bit down-counter with one-shot / auto-reload
// underflow interrupt. Read data is registered (valid the cycle after the
// address). Optional compare/PWM output is built when TIMER_PWM_EN is defined.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       reset,
    bus_timer_if.slave bus
);

    logic        wr_s, rd_s;
    logic        wr_lo_s, wr_hi_s, wr_ctrl_s, wr_stat_s;
    logic        tick_s, tick_eff_s, underflow_s;
    logic [15:0] reload_new_s;
    logic [7:0]  rd_mux_s;
    logic [15:0] count_nxt_s;
    logic [2:0]  ctrl_nxt_s;
    logic        flag_nxt_s;

    logic [15:0] count_r;
    logic [15:0] reload_r;
    logic [7:0]  lo_stage_r;
    logic [7:0]  hi_snap_r;
    logic [2:0]  ctrl_r;
    logic        flag_r;
    logic [7:0]  dout_r;
    logic        irq_r;
    logic        pwm_r;

`ifdef TIMER_PWM_EN
    logic        wr_cmp_lo_s, wr_cmp_hi_s;
    logic [7:0]  cmp_stage_r;
    logic [15:0] cmp_r;

    assign wr_cmp_lo_s = wr_s & (bus.rs == TMR_CMP_LO);
    assign wr_cmp_hi_s = wr_s & (bus.rs == TMR_CMP_HI);
`endif

    bus_timer_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl_r[CTRL_EN]),
        .tick  (tick_s)
    );

    assign wr_s         = bus.cs & bus.we;
    assign rd_s         = bus.cs & ~bus.we;
    assign reload_new_s = {bus.din, lo_stage_r};

    // Write strobe decode for the core registers
    always_comb begin
        wr_lo_s   = 1'b0;
        wr_hi_s   = 1'b0;
        wr_ctrl_s = 1'b0;
        wr_stat_s = 1'b0;
        if (wr_s) begin
            case (bus.rs)
                TMR_CNT_LO: wr_lo_s   = 1'b1;
                TMR_CNT_HI: wr_hi_s   = 1'b1;
                TMR_CTRL:   wr_ctrl_s = 1'b1;
                TMR_STATUS: wr_stat_s = 1'b1;
                default:    wr_lo_s   = 1'b0;
            endcase
        end else begin
            wr_lo_s = 1'b0;
        end
    end

    // Read data selection; unused addresses read zero
    always_comb begin
        rd_mux_s = 8'h00;
        case (bus.rs)
            TMR_CNT_LO: rd_mux_s = count_r[7:0];
            TMR_CNT_HI: rd_mux_s = hi_snap_r;
            TMR_CTRL:   rd_mux_s = ctrl_byte(ctrl_r);
            TMR_STATUS: rd_mux_s = status_byte(flag_r);
`ifdef TIMER_PWM_EN
            TMR_CMP_LO: rd_mux_s = cmp_r[7:0];
            TMR_CMP_HI: rd_mux_s = cmp_r[15:8];
`endif
            default:    rd_mux_s = 8'h00;
        endcase
    end

    // A CTRL write clearing EN cancels a coincident tick entirely
    assign tick_eff_s  = tick_s & ~(wr_ctrl_s & ~bus.din[CTRL_EN]);
    assign underflow_s = tick_eff_s & (count_r == 16'h0000);

    // Counter / control / flag next state
    always_comb begin
        count_nxt_s = count_r;
        ctrl_nxt_s  = ctrl_r;
        flag_nxt_s  = flag_r;

        if (tick_eff_s) begin
            if (count_r != 16'h0000) begin
                count_nxt_s = count_r - 16'd1;
            end else if (ctrl_r[CTRL_AUTO]) begin
                // A reload committed this very cycle takes effect immediately
                count_nxt_s = wr_hi_s ? reload_new_s : reload_r;
            end else begin
                count_nxt_s = 16'h0000;
            end
        end else if (wr_hi_s && !ctrl_r[CTRL_EN]) begin
            count_nxt_s = reload_new_s;
        end else begin
            count_nxt_s = count_r;
        end

        if (wr_ctrl_s) begin
            ctrl_nxt_s = bus.din[2:0];
        end else if (underflow_s && !ctrl_r[CTRL_AUTO]) begin
            ctrl_nxt_s[CTRL_EN] = 1'b0;
        end else begin
            ctrl_nxt_s = ctrl_r;
        end

        // Underflow set has priority over a software clear
        if (underflow_s) begin
            flag_nxt_s = 1'b1;
        end else if (wr_stat_s && bus.din[STATUS_FLAG]) begin
            flag_nxt_s = 1'b0;
        end else begin
            flag_nxt_s = flag_r;
        end
    end

    // Reload staging, reload commit and high-byte read snapshot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lo_stage_r <= 8'h00;
            reload_r   <= 16'h0000;
            hi_snap_r  <= 8'h00;
        end else begin
            if (wr_lo_s) begin
                lo_stage_r <= bus.din;
            end
            if (wr_hi_s) begin
                reload_r <= reload_new_s;
            end
            if (rd_s && (bus.rs == TMR_CNT_LO)) begin
                hi_snap_r <= count_r[15:8];
            end
        end
    end

    // Timer core state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= 16'h0000;
            ctrl_r  <= 3'b000;
            flag_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            ctrl_r  <= ctrl_nxt_s;
            flag_r  <= flag_nxt_s;
        end
    end

`ifdef TIMER_PWM_EN
    // Compare register: low byte staged, high byte write commits both
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_stage_r <= 8'h00;
            cmp_r       <= 16'h0000;
        end else begin
            if (wr_cmp_lo_s) begin
                cmp_stage_r <= bus.din;
            end
            if (wr_cmp_hi_s) begin
                cmp_r <= {bus.din, cmp_stage_r};
            end
        end
    end
`endif

    // Registered bus-facing outputs: read data, interrupt and compare output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_r <= 8'h00;
            irq_r  <= 1'b0;
            pwm_r  <= 1'b0;
        end else begin
            if (rd_s) begin
                dout_r <= rd_mux_s;
            end
            irq_r <= flag_r & ctrl_r[CTRL_IE];
`ifdef TIMER_PWM_EN
            pwm_r <= ctrl_r[CTRL_EN] & (count_r < cmp_r);
`else
            pwm_r <= 1'b0;
`endif
        end
    end

    assign bus.dout = dout_r;
    assign bus.irq  = irq_r;
    assign bus.pwm  = pwm_r;

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: self-checking bench for bus_timer. Two instances (PRESCALE=4
// and PRESCALE=1) share the same bus stimulus; expected read data is queued
// when a read is issued and popped when the registered data appears.
module tb_bus_timer;
    import bus_timer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs, we;
    logic [2:0] rs;
    logic [7:0] din;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    bus_timer_if bif4();
    bus_timer_if bif1();

    assign bif4.cs = cs;  assign bif4.we = we;  assign bif4.rs = rs;  assign bif4.din = din;
    assign bif1.cs = cs;  assign bif1.we = we;  assign bif1.rs = rs;  assign bif1.din = din;

    bus_timer #(.PRESCALE(4)) u_dut4 (.clk(clk), .reset(rst_n), .bus(bif4));
    bus_timer #(.PRESCALE(1)) u_dut1 (.clk(clk), .reset(rst_n), .bus(bif1));

    // All tasks start and end on a falling edge of clk
    task automatic do_reset();
        rst_n = 1'b0; cs = 1'b0; we = 1'b0; rs = 3'd0; din = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; rs = a; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input bit p1, output logic [7:0] d);
        cs = 1'b1; we = 1'b0; rs = a;
        @(negedge clk);
        cs = 1'b0;
        d = p1 ? bif1.dout : bif4.dout;
    endtask

    task automatic test_reset();
        logic [7:0] obs, e;
        do_reset();
        n_checks++;
        if ({bif4.irq, bif4.pwm, bif1.irq, bif1.pwm} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_irq_pwm: got %b expected 0000", {bif4.irq, bif4.pwm, bif1.irq, bif1.pwm});
        end
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 8; a++) begin
                exp_q.push_back(8'h00);
                bus_read(3'(a), p[0], obs);
                e = exp_q.pop_front();
                n_checks++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL reset_read p%0d a%0d: got %h expected %h", p, a, obs, e);
                end
            end
        end
        bus_write(TMR_CTRL, 8'h07);
        exp_q.push_back(8'h07);
        bus_read(TMR_CTRL, 1'b0, obs);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL ctrl_readback: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_one_shot();
        logic [7:0] obs, e;
        logic [2:0] addrs [4] = '{TMR_CTRL, TMR_CNT_LO, TMR_CNT_HI, TMR_STATUS};
        do_reset();
        bus_write(TMR_CNT_LO, 8'h03);
        bus_write(TMR_CNT_HI, 8'h00);
        bus_write(TMR_CTRL, 8'h05);
        idle(16);
        n_checks++;
        if (bif4.irq !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_irq_early: got %b expected 0", bif4.irq);
        end
        idle(1);
        n_checks++;
        if (bif4.irq !== 1'b1) begin
            n_fail++;
            $display("FAIL oneshot_irq_rise: got %b expected 1", bif4.irq);
        end
        idle(8);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        for (int i = 0; i < 4; i++) begin
            bus_read(addrs[i], 1'b0, obs);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL oneshot_read%0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_auto_reload();
        logic [7:0] obs, e;
        logic       exp_irq [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int         waits   [6] = '{12, 1, 0, 1, 9, 1};
        do_reset();
        bus_write(TMR_CNT_LO, 8'h02);
        bus_write(TMR_CNT_HI, 8'h00);
        bus_write(TMR_CTRL, 8'h07);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                bus_write(TMR_STATUS, 8'h01);
            end
            idle(waits[i]);
            n_checks++;
            if (bif4.irq !== exp_irq[i]) begin
                n_fail++;
                $display("FAIL auto_irq step%0d: got %b expected %b", i, bif4.irq, exp_irq[i]);
            end
        end
        // Reset in the middle of operation with the flag pending
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bif4.irq !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset_irq: got %b expected 0", bif4.irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(8'h00);
        bus_read(TMR_STATUS, 1'b0, obs);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL midrun_reset_status: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_atomic_read();
        logic [7:0]  obs, e;
        logic [15:0] m;
        do_reset();
        bus_write(TMR_CNT_LO, 8'h00);
        bus_write(TMR_CNT_HI, 8'h01);
        bus_write(TMR_CTRL, 8'h01);
        for (int k = 0; k < 2; k++) begin
            // Value seen by the CNT_LO read: one decrement per clk since enable
            m = 16'h0100 - 16'(2 * k);
            exp_q.push_back(m[7:0]);
            exp_q.push_back(m[15:8]);
            bus_read(TMR_CNT_LO, 1'b1, obs);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL atomic_lo%0d: got %h expected %h", k, obs, e);
            end
            bus_read(TMR_CNT_HI, 1'b1, obs);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL atomic_hi%0d: got %h expected %h", k, obs, e);
            end
        end
    endtask

    task automatic test_collision();
        logic [7:0] obs, e;
        // Underflow coincident with STATUS clear: flag stays set
        do_reset();
        bus_write(TMR_CTRL, 8'h03);
        idle(3);
        bus_write(TMR_STATUS, 8'h01);
        exp_q.push_back(8'h01);
        bus_read(TMR_STATUS, 1'b0, obs);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL collide_set_wins: got %h expected %h", obs, e);
        end
        // Clear away from a tick does clear
        bus_write(TMR_STATUS, 8'h01);
        exp_q.push_back(8'h00);
        bus_read(TMR_STATUS, 1'b0, obs);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL status_clear: got %h expected %h", obs, e);
        end
        // CTRL write EN=0 coincident with a tick: no decrement
        do_reset();
        bus_write(TMR_CNT_LO, 8'h05);
        bus_write(TMR_CNT_HI, 8'h00);
        bus_write(TMR_CTRL, 8'h01);
        idle(7);
        bus_write(TMR_CTRL, 8'h00);
        exp_q.push_back(8'h04);
        bus_read(TMR_CNT_LO, 1'b0, obs);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL collide_ctrl_tick: got %h expected %h", obs, e);
        end
        // RELOAD_HI commit coincident with an underflow tick: new reload used
        do_reset();
        bus_write(TMR_CNT_LO, 8'h07);
        bus_write(TMR_CTRL, 8'h03);
        idle(3);
        bus_write(TMR_CNT_HI, 8'h00);
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h01);
        bus_read(TMR_CNT_LO, 1'b0, obs);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL collide_reload_cnt: got %h expected %h", obs, e);
        end
        bus_read(TMR_STATUS, 1'b0, obs);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL collide_reload_flag: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_pwm();
        logic [7:0] obs, e;
        int ones1, ones4, exp1;
        do_reset();
        bus_write(TMR_CNT_LO, 8'h09);
        bus_write(TMR_CNT_HI, 8'h00);
        bus_write(TMR_CMP_LO, 8'h05);
        bus_write(TMR_CMP_HI, 8'h00);
`ifdef TIMER_PWM_EN
        exp_q.push_back(8'h05);
        exp1 = 10;
`else
        exp_q.push_back(8'h00);
        exp1 = 0;
`endif
        bus_read(TMR_CMP_LO, 1'b1, obs);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL cmp_lo_read: got %h expected %h", obs, e);
        end
        bus_write(TMR_CTRL, 8'h03);
        idle(2);
        ones1 = 0;
        ones4 = 0;
        repeat (20) begin
            @(negedge clk);
            ones1 += int'(bif1.pwm);
            ones4 += int'(bif4.pwm);
        end
        n_checks++;
        if (ones1 !== exp1) begin
            n_fail++;
            $display("FAIL pwm_duty: got %0d high cycles expected %0d", ones1, exp1);
        end
`ifndef TIMER_PWM_EN
        n_checks++;
        if (ones4 !== 0) begin
            n_fail++;
            $display("FAIL pwm_off_p4: got %0d high cycles expected 0", ones4);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b0; we = 1'b0; rs = 3'd0; din = 8'h00;
        @(negedge clk);
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_atomic_read();
        test_collision();
        test_pwm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped 16-bit down-counter/timer peripheral. It is a responder on the 65C02 system bus.
- Sits beside the ACIA in the page-decoded I/O space. It has a registered read path, so read data is valid the cycle after the address, matching the SoC's registered data mux.
- Provides periodic or one-shot underflow interrupts to the CPU IRQ line. The IRQ is wire-ORed at SoC level.

Parameters:
- PRESCALE, 4, clk cycles per timer tick (>=1); prescaler counter width is clog2(PRESCALE)+1.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- cs  input  1  chip select from page decode
- we  input  1  write enable, qualified by cs
- rs  input  3  register select (CPU_AB[2:0])
- din  input  8  write data (CPU_DO)
- dout  output  8  registered read data
- irq  output  1  interrupt request, active high
- pwm  output  1  compare output; constant 0 unless TIMER_PWM_EN is defined

Behaviour:
- Reset (async, reset=0) clears all state:
  - count=0, reload=0, lo_stage=0, hi_snap=0
  - ctrl=0, flag=0, prescaler=0
  - dout=0, irq=0, pwm=0
- Register map (write / read):
  - 0: RELOAD_LO staging / CNT_LO. Reading CNT_LO snapshots count[15:8] into hi_snap.
  - 1: RELOAD_HI (commit) / hi_snap.
  - 2: CTRL r/w. Bit0 EN, bit1 AUTO, bit2 IE; bits 7:3 read 0.
  - 3: STATUS. Bit0 flag; writing 1 to bit0 clears it.
  - 4,5: CMP_LO/CMP_HI (TIMER_PWM_EN only). Otherwise reads 0 and writes are ignored.
  - 6,7: read 0, writes ignored.
- Write rules:
  - Write occurs when cs&we.
  - RELOAD_HI write sets reload={din,lo_stage}. If EN=0, it also sets count={din,lo_stage}.
- Read rules:
  - dout<=mux(rs) every cycle cs&~we; otherwise dout holds its value.
  - Read side effects (the hi_snap latch) occur only on cs&~we.
- Tick:
  - Prescaler runs only while EN=1; EN=0 holds it at 0.
  - Tick fires when the prescaler reaches PRESCALE-1, and the prescaler then wraps to 0.
  - PRESCALE=1 gives a tick every clk.
- Count on tick:
  - count!=0: count-1.
  - count==0 (underflow): flag<=1. If AUTO, count<=reload; else count stays 0 and EN<=0 (one-shot).
  - reload=0 with AUTO gives flag every tick.
- Wrap: count is 16-bit unsigned and never decrements below 0.
- irq: registered, irq<=flag&IE. It is asserted 1 clk after flag sets or IE sets, and deasserts 1 clk after clear.
- Simultaneous events:
  - Underflow and STATUS clear in the same cycle: set wins, flag stays 1.
  - RELOAD_HI commit and tick in the same cycle (EN=1): reload updates, the tick proceeds on the old count, and an underflow reload uses the new reload value.
  - CTRL write setting EN=0 and tick in the same cycle: the write wins, no decrement.
- Enabling: writing EN 0->1 resets the prescaler, so the first tick is PRESCALE clks after the write.
- Mid-operation reset: immediate return to reset values; no pending flag survives.

Optional Feature:
- Macro: TIMER_PWM_EN.
- Defined:
  - Adds a 16-bit cmp register (reset 0), loaded via CMP_LO staging plus a CMP_HI commit.
  - pwm<=EN&(count<cmp), registered.
  - cmp=0 gives pwm=0; cmp>reload gives pwm=1 while EN.
- Undefined:
  - No cmp register; pwm tied to 0; addresses 4,5 behave as unused.

Decomposition:
- Shared package bus_timer_pkg:
  - Register address constants (TMR_CNT_LO..TMR_CMP_HI).
  - CTRL bit indices (CTRL_EN, CTRL_AUTO, CTRL_IE).
  - STATUS bit index.
- One natural sub-module: bus_timer_prescale. It holds the prescaler counter, with clear input en and output tick.

Test Plan:
- Reset/readback: after reset, read all 8 addresses -> all 0x00, irq=0, pwm=0. A CTRL write 0x07 reads back 0x07 one clk later.
- One-shot: PRESCALE=4, write reload 0x0003 (LO=03, HI=00), then CTRL=0x05.
  - flag sets 16 clks after the CTRL write; irq rises 1 clk later.
  - EN reads 0 and count stays 0x0000.
- Auto-reload: reload 0x0002, CTRL=0x07 -> flag every 12 clks. Clear via STATUS=0x01 -> irq drops 1 clk later, then reasserts on the next underflow.
- Atomic read: count=0x0100, EN=1, PRESCALE=1. Read CNT_LO (0x00 or 0xFF, depending on the tick), then CNT_HI -> a value consistent with the snapshot despite decrements in between.
- Collision: force an underflow on the same clk as a STATUS write 0x01 -> flag remains 1. A CTRL write 0x00 coincident with a tick -> count unchanged.
- PWM (TIMER_PWM_EN): reload 0x0009, cmp 0x0005, AUTO+EN, PRESCALE=1 -> pwm high 5 of every 10 ticks. Undefined: pwm constantly 0.
